// File: rtl/sdio_cmd_tx_if.sv
// sdio_cmd_tx_if: command request handshake between the SDIO controller and sdio_cmd_tx.
interface sdio_cmd_tx_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    modport master (output cmd_valid, cmd_index, cmd_arg, input cmd_ready);
    modport slave  (input cmd_valid, cmd_index, cmd_arg, output cmd_ready);
endinterface

// File: rtl/sdio_cmd_tx.sv
// sdio_cmd_tx: serializes a 48-bit SD command frame onto CMD, appending CRC7 from an external generator.
// Define SDIO_CMD_TX_PREAMBLE_EN to drive PREAMBLE_BITS ones ahead of the start bit.
module sdio_cmd_tx #(
    parameter int unsigned PREAMBLE_BITS = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         sdclk_en_i,
    sdio_cmd_tx_if.slave cmd_if,
    output logic         crc_data_o,
    output logic         crc_sample_o,
    output logic         crc_shift_o,
    output logic         crc_clr_o,
    input  logic         crc_serial_i,
    output logic         sd_cmd_o,
    output logic         sd_cmd_oen_o,
    output logic         busy_o,
    output logic         done_o
);
    typedef enum logic [2:0] {
        IDLE,
`ifdef SDIO_CMD_TX_PREAMBLE_EN
        PRE,
`endif
        SEND,
        CRC,
        END,
        RELEASE
    } state_e;

    if (PREAMBLE_BITS < 1 || PREAMBLE_BITS > 15) begin : g_bad_preamble
        $error("PREAMBLE_BITS must be in 1..15");
    end

    state_e      state_q;
    logic [39:0] shreg_q;
    logic [5:0]  cnt_q;
    logic        accept;
`ifdef SDIO_CMD_TX_PREAMBLE_EN
    logic [3:0]  pre_cnt_q;
`endif

    assign cmd_if.cmd_ready = state_q == IDLE;
    assign accept           = cmd_if.cmd_valid & cmd_if.cmd_ready;
    assign busy_o           = state_q != IDLE;
    // CRC7 strobes are mutually exclusive by construction: clr only in IDLE, sample in SEND, shift in CRC
    assign crc_clr_o        = accept;
    assign crc_sample_o     = state_q == SEND & sdclk_en_i;
    assign crc_shift_o      = state_q == CRC & sdclk_en_i;
    assign crc_data_o       = state_q == SEND & shreg_q[39];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            cnt_q        <= '0;
            sd_cmd_o     <= 1'b1;
            sd_cmd_oen_o <= 1'b1;
            done_o       <= 1'b0;
`ifdef SDIO_CMD_TX_PREAMBLE_EN
            pre_cnt_q    <= '0;
`endif
        end else begin
            done_o <= 1'b0;
            if (accept) begin
                shreg_q <= {2'b01, cmd_if.cmd_index, cmd_if.cmd_arg};
                cnt_q   <= 6'd39;
`ifdef SDIO_CMD_TX_PREAMBLE_EN
                pre_cnt_q <= 4'(PREAMBLE_BITS - 1);
                state_q   <= PRE;
`else
                state_q <= SEND;
`endif
            end else if (sdclk_en_i) begin
                case (state_q)
`ifdef SDIO_CMD_TX_PREAMBLE_EN
                    PRE: begin
                        sd_cmd_o     <= 1'b1;
                        sd_cmd_oen_o <= 1'b0;
                        pre_cnt_q    <= pre_cnt_q - 4'd1;
                        if (pre_cnt_q == 4'd0) state_q <= SEND;
                    end
`endif
                    SEND: begin
                        sd_cmd_o     <= shreg_q[39];
                        sd_cmd_oen_o <= 1'b0;
                        shreg_q      <= {shreg_q[38:0], 1'b0};
                        cnt_q        <= cnt_q == 6'd0 ? 6'd6 : cnt_q - 6'd1;
                        if (cnt_q == 6'd0) state_q <= CRC;
                    end
                    // crc_serial_i already reflects the last sampled bit, so it is valid on the first CRC tick
                    CRC: begin
                        sd_cmd_o     <= crc_serial_i;
                        sd_cmd_oen_o <= 1'b0;
                        cnt_q        <= cnt_q - 6'd1;
                        if (cnt_q == 6'd0) state_q <= END;
                    end
                    END: begin
                        sd_cmd_o     <= 1'b1;
                        sd_cmd_oen_o <= 1'b0;
                        state_q      <= RELEASE;
                    end
                    RELEASE: begin
                        sd_cmd_o     <= 1'b1;
                        sd_cmd_oen_o <= 1'b1;
                        done_o       <= 1'b1;
                        state_q      <= IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sdio_cmd_tx.sv
// tb_sdio_cmd_tx: scoreboard bench for sdio_cmd_tx with a behavioural CRC7 generator on the strobe interface.
module tb_sdio_cmd_tx;
    localparam int PRE_N = 2;
`ifdef SDIO_CMD_TX_PREAMBLE_EN
    localparam int EXP_PRE = PRE_N;
`else
    localparam int EXP_PRE = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sdclk_en = 1'b0;
    logic crc_data, crc_sample, crc_shift, crc_clr, crc_serial;
    logic sd_cmd, sd_cmd_oen, busy, done;
    logic [6:0] crc_q = '0;
    logic [47:0] sb[$];
    int n_chk = 0;
    int n_fail = 0;
    int en_period = 1;
    int ph = 0;

    sdio_cmd_tx_if cmd_if();

    sdio_cmd_tx #(.PREAMBLE_BITS(PRE_N)) dut (
        .clk_i(clk), .rst_i(rst), .sdclk_en_i(sdclk_en), .cmd_if(cmd_if),
        .crc_data_o(crc_data), .crc_sample_o(crc_sample), .crc_shift_o(crc_shift),
        .crc_clr_o(crc_clr), .crc_serial_i(crc_serial),
        .sd_cmd_o(sd_cmd), .sd_cmd_oen_o(sd_cmd_oen), .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    // CRC7 (x^7 + x^3 + 1) generator driven by the DUT strobes
    assign crc_serial = crc_q[6];
    always @(posedge clk) begin
        if (crc_clr) crc_q <= '0;
        else if (crc_sample) crc_q <= {crc_q[5:0], 1'b0} ^ ((crc_q[6] ^ crc_data) ? 7'h09 : 7'h00);
        else if (crc_shift) crc_q <= {crc_q[5:0], 1'b0};
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [47:0] frame_of(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] m;
        logic [6:0] c;
        m = {2'b01, idx, arg};
        c = '0;
        for (int i = 39; i >= 0; i--) c = {c[5:0], 1'b0} ^ ((c[6] ^ m[i]) ? 7'h09 : 7'h00);
        return {m, c, 1'b1};
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            ph++;
            sdclk_en = (ph % en_period) == 0;
        end
    end

    // CMD line monitor: rebuilds frames, counts ticks and strobes, checks at each done_o
    logic tick_q = 1'b0;
    always @(posedge clk) tick_q <= sdclk_en;
    logic [47:0] frame, exp_frame;
    logic started, prev_cmd, prev_oen;
    int nbits, npre, ticks, n_smp, n_shf, n_clr, proto, hold_err;

    always @(negedge clk) begin
        if (rst) begin
            started = 1'b0; frame = '0; nbits = 0; npre = 0; ticks = 0;
            n_smp = 0; n_shf = 0; n_clr = 0; proto = 0; hold_err = 0;
        end else begin
            if (done) begin
                if (sb.size() == 0) check("unexpected_frame", frame, 48'h0);
                else begin
                    exp_frame = sb.pop_front();
                    check("frame", frame, exp_frame);
                end
                check("nbits", nbits, 48);
                check("preamble", npre, EXP_PRE);
                check("ticks_to_done", ticks, 49 + EXP_PRE);
                check("n_sample", n_smp, 40);
                check("n_shift", n_shf, 7);
                check("n_clr", n_clr, 1);
                check("protocol", proto, 0);
                check("hold", hold_err, 0);
                started = 1'b0; frame = '0; nbits = 0; npre = 0; ticks = 0;
                n_smp = 0; n_shf = 0; n_clr = 0; proto = 0; hold_err = 0;
            end
            if (!tick_q && (sd_cmd !== prev_cmd || sd_cmd_oen !== prev_oen)) hold_err++;
            if (tick_q && !sd_cmd_oen) begin
                if (started) begin
                    frame = {frame[46:0], sd_cmd};
                    nbits++;
                end else if (!sd_cmd) begin
                    started = 1'b1;
                    frame = '0;
                    nbits = 1;
                end else npre++;
            end
            if (sdclk_en && busy) ticks++;
            n_clr += int'(crc_clr);
            n_smp += int'(crc_sample);
            n_shf += int'(crc_shift);
            if (int'(crc_clr) + int'(crc_sample) + int'(crc_shift) > 1 ||
                (busy && cmd_if.cmd_ready) || (!busy && crc_data)) proto++;
        end
        prev_cmd = sd_cmd;
        prev_oen = sd_cmd_oen;
    end

    task automatic send(input logic [5:0] idx, input logic [31:0] arg, input logic [47:0] exp);
        int n = 0;
        while (!cmd_if.cmd_ready && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("ready_before_send", cmd_if.cmd_ready, 1);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_index = idx;
        cmd_if.cmd_arg   = arg;
        sb.push_back(exp);
        @(posedge clk);
        #1;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_index = 6'($urandom);
        cmd_if.cmd_arg   = $urandom;
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!done && n < 2000);
        check("done_seen", done, 1);
    endtask

    initial begin
        logic [5:0] ri;
        logic [31:0] ra;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_index = '0;
        cmd_if.cmd_arg   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd", sd_cmd, 1);
        check("rst_oen", sd_cmd_oen, 1);
        check("rst_done", done, 0);
        check("rst_ready", cmd_if.cmd_ready, 1);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        send(6'd0, 32'h0, 48'h400000000095);
        wait_done();
        en_period = 4;
        send(6'd17, 32'h0, 48'h510000000055);
        wait_done();
        en_period = 1;
        send(6'd8, 32'h000001AA, 48'h48000001AA87);
        wait_done();
        send(6'd55, 32'hDEADBEEF, frame_of(6'd55, 32'hDEADBEEF));
        repeat (10) @(posedge clk);
        #1;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_index = 6'd12;
        repeat (5) @(posedge clk);
        #1;
        cmd_if.cmd_valid = 1'b0;
        wait_done();
        send(6'd41, 32'h40FF8000, frame_of(6'd41, 32'h40FF8000));
        wait_done();
        send(6'd2, 32'h0, frame_of(6'd2, 32'h0));
        wait_done();
        send(6'd0, 32'h0, 48'h400000000095);
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_oen", sd_cmd_oen, 1);
        check("midrst_cmd", sd_cmd, 1);
        check("midrst_ready", cmd_if.cmd_ready, 1);
        check("midrst_done", done, 0);
        check("midrst_strobes", {crc_clr, crc_sample, crc_shift}, 3'b000);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        send(6'd0, 32'h0, 48'h400000000095);
        wait_done();
        for (int k = 0; k < 3; k++) begin
            en_period = int'($urandom_range(3, 1));
            ri = 6'($urandom);
            ra = $urandom;
            send(ri, ra, frame_of(ri, ra));
            wait_done();
        end
        repeat (5) @(posedge clk);
        #1;
        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
